multi_edge_detector: RTL and testbench
======================================

MULTI_EDGE_DETECTOR -- requirements
Module: multi_edge_detector

Interface
REQ-001 Parameter CHANNELS, default 8, number of independent input channels (1..32).
REQ-002 Parameter SYNC_STAGES, default 2, synchroniser flops per channel (2..4).
REQ-003 Parameter CNT_WIDTH, default 8, width of each per-channel saturating edge counter.
REQ-004 clock  input  1  single clock; all logic on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 data  input  CHANNELS  asynchronous level inputs, one bit per channel.
REQ-007 mode  input  2*CHANNELS  per-channel mode, bits [2i+1:2i]: 00 off, 01 rising, 10 falling, 11 both.
REQ-008 clear  input  CHANNELS  write-one-to-clear for the channel flag and counter, sampled each cycle.
REQ-009 detector  output  CHANNELS  one-cycle registered pulse per qualifying edge.
REQ-010 event_flag  output  CHANNELS  sticky per-channel "edge seen" flag.
REQ-011 edge_count  output  CHANNELS*CNT_WIDTH  per-channel counter, channel i at bits [i*CNT_WIDTH +: CNT_WIDTH].
REQ-012 any_event  output  1  registered OR of event_flag.

Function
REQ-013 Each channel SHALL pass data[i] through SYNC_STAGES flops, then one history flop (prev).
REQ-014 Rising edge SHALL be sync_last=1 & prev=0; falling SHALL be sync_last=0 & prev=1.
REQ-015 An edge SHALL qualify only if it matches the channel's mode in the same cycle; mode 00 never qualifies.
REQ-016 Latency: data change ahead of clock edge k SHALL give detector[i]=1 for exactly the cycle after edge k+SYNC_STAGES.
REQ-017 detector[i] SHALL be 1 for one cycle per qualifying edge; back-to-back edges on consecutive synchronised samples SHALL give consecutive pulses.
REQ-018 A qualifying edge SHALL set event_flag[i] on the same edge that raises detector[i].
REQ-019 A qualifying edge SHALL increment edge_count[i] on that edge; at all-ones the counter SHALL hold (saturate, no wrap).
REQ-020 clear[i]=1 SHALL zero event_flag[i] and edge_count[i] on the next edge.
REQ-021 clear[i] and a qualifying edge in the same cycle: edge wins; event_flag[i]=1, edge_count[i]=1.
REQ-022 Mode changes SHALL take effect on the next clock edge, with no retroactive detection.
REQ-023 any_event SHALL equal the OR of event_flag delayed one cycle.
REQ-024 Channels SHALL be fully independent; activity on one SHALL not affect any other.

Reset
REQ-025 reset_n=0 SHALL asynchronously clear all synchroniser, prev, detector, event_flag, edge_count and any_event flops to 0.
REQ-026 A priming counter SHALL inhibit detection for SYNC_STAGES+1 edges after reset release, so inputs already high are not reported as rising edges.
REQ-027 During priming the sync and prev flops SHALL still load, while detector, flags and counters stay 0.
REQ-028 Reset asserted mid-pulse SHALL drop detector immediately; no pending edge survives reset.

Structure
REQ-029 Package multi_edge_detector_pkg SHALL hold the mode typedef (OFF, RISE, FALL, BOTH) and the default parameter constants.
REQ-030 Per-channel logic SHALL be one sub-module, edge_channel (sync chain, prev, qualify, flag, counter), instantiated CHANNELS times by generate.
REQ-031 The top level SHALL hold only the priming counter, channel instances and any_event.

Verification
REQ-032 Defaults, all modes 01, data[0] 0->1 six cycles after reset release -> detector[0] pulses 1 cycle, 3 edges after change; event_flag[0]=1; edge_count[0]=1.
REQ-033 data=0xFF held through reset, mode 11 -> no detector pulses and count 0 after release; a later drop to 0x00 gives 8 simultaneous pulses.
REQ-034 Channel 2 mode 10, toggled 0->1->0 -> only the falling edge pulses; mode 01 on the same pattern -> only the rising edge pulses.
REQ-035 CNT_WIDTH=4, mode 11, 20 edges on channel 1 -> edge_count[1] holds at 15; clear[1] -> 0 next cycle.
REQ-036 clear[3] in the same cycle as a qualifying edge -> event_flag[3]=1, edge_count[3]=1; any_event=1 one cycle later.
REQ-037 reset_n pulsed low while detector[0]=1 -> all outputs 0 asynchronously; the priming window repeats after release.

Source files
------------

// File: rtl/multi_edge_detector_pkg.sv
// Shared types and default constants for the multi-channel edge detector.
// Holds the per-channel mode encoding and the mode/edge qualification helper.
package multi_edge_detector_pkg;

  typedef enum logic [1:0] {
    OFF  = 2'b00,
    RISE = 2'b01,
    FALL = 2'b10,
    BOTH = 2'b11
  } edge_mode_e;

  localparam int DEFAULT_CHANNELS    = 8;
  localparam int DEFAULT_SYNC_STAGES = 2;
  localparam int DEFAULT_CNT_WIDTH   = 8;

  function automatic logic edge_qualifies(input edge_mode_e m, input logic rise, input logic fall);
    return (((m == RISE) || (m == BOTH)) && rise) || (((m == FALL) || (m == BOTH)) && fall);
  endfunction

endpackage

// File: rtl/multi_edge_detector_edge_channel.sv
// One detector channel: synchroniser chain, history flop, mode qualification,
// sticky flag and saturating edge counter.
module edge_channel
  import multi_edge_detector_pkg::*;
#(
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
  parameter int CNT_WIDTH   = DEFAULT_CNT_WIDTH
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic                 data,
  input  edge_mode_e           mode,
  input  logic                 clear,
  output logic                 detector,
  output logic                 event_flag,
  output logic [CNT_WIDTH-1:0] edge_count
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   prev_reg;
  logic                   detector_reg, detector_next;
  logic                   flag_reg, flag_next;
  logic [CNT_WIDTH-1:0]   count_reg, count_next;
  logic                   rise, fall, qualify;

  always_comb begin
    rise          = sync_reg[SYNC_STAGES-1] & ~prev_reg;
    fall          = ~sync_reg[SYNC_STAGES-1] & prev_reg;
    qualify       = enable & edge_qualifies(mode, rise, fall);
    detector_next = qualify;
    flag_next     = flag_reg;
    count_next    = count_reg;
    // A simultaneous clear restarts the count at this edge rather than dropping it.
    if (qualify) begin
      flag_next  = 1'b1;
      if (clear)
        count_next = CNT_WIDTH'(1);
      else if (!(&count_reg))
        count_next = count_reg + 1'b1;
    end else if (clear) begin
      flag_next  = 1'b0;
      count_next = '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_reg     <= '0;
      prev_reg     <= 1'b0;
      detector_reg <= 1'b0;
      flag_reg     <= 1'b0;
      count_reg    <= '0;
    end else begin
      sync_reg     <= {sync_reg[SYNC_STAGES-2:0], data};
      prev_reg     <= sync_reg[SYNC_STAGES-1];
      detector_reg <= detector_next;
      flag_reg     <= flag_next;
      count_reg    <= count_next;
    end
  end

  assign detector   = detector_reg;
  assign event_flag = flag_reg;
  assign edge_count = count_reg;

endmodule

// File: rtl/multi_edge_detector.sv
// Multi-channel edge detector: priming counter after reset, per-channel
// detectors and a registered summary of all sticky flags.
module multi_edge_detector
  import multi_edge_detector_pkg::*;
#(
  parameter int CHANNELS    = DEFAULT_CHANNELS,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
  parameter int CNT_WIDTH   = DEFAULT_CNT_WIDTH
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [CHANNELS-1:0]           data,
  input  logic [2*CHANNELS-1:0]         mode,
  input  logic [CHANNELS-1:0]           clear,
  output logic [CHANNELS-1:0]           detector,
  output logic [CHANNELS-1:0]           event_flag,
  output logic [CHANNELS*CNT_WIDTH-1:0] edge_count,
  output logic                          any_event
);

  localparam int PRIME_W = $clog2(SYNC_STAGES + 2);
  localparam logic [PRIME_W-1:0] PRIME_DONE = PRIME_W'(SYNC_STAGES + 1);

  logic [PRIME_W-1:0] prime_cnt_reg;
  logic               enable;
  logic               any_event_reg;

  // Detection stays off until the sync chain and history flop hold real samples.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      prime_cnt_reg <= '0;
    else if (prime_cnt_reg != PRIME_DONE)
      prime_cnt_reg <= prime_cnt_reg + 1'b1;
  end

  assign enable = (prime_cnt_reg == PRIME_DONE);

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
      edge_channel #(
        .SYNC_STAGES(SYNC_STAGES),
        .CNT_WIDTH  (CNT_WIDTH)
      ) u_ch (
        .clock     (clock),
        .reset_n   (reset_n),
        .enable    (enable),
        .data      (data[gi]),
        .mode      (edge_mode_e'(mode[2*gi +: 2])),
        .clear     (clear[gi]),
        .detector  (detector[gi]),
        .event_flag(event_flag[gi]),
        .edge_count(edge_count[gi*CNT_WIDTH +: CNT_WIDTH])
      );
    end
  endgenerate

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      any_event_reg <= 1'b0;
    else
      any_event_reg <= |event_flag;
  end

  assign any_event = any_event_reg;

endmodule

// File: tb/tb_multi_edge_detector.sv
// Directed bench for multi_edge_detector: default instance plus a 4-bit-counter
// instance sharing the same stimulus.
module tb_multi_edge_detector;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [7:0]  data;
  logic [15:0] mode;
  logic [7:0]  clear;
  logic [7:0]  det, flag, det4, flag4;
  logic [63:0] cnt;
  logic [31:0] cnt4;
  logic        any_ev, any_ev4;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  multi_edge_detector dut (
    .clock(clock), .reset_n(reset_n), .data(data), .mode(mode), .clear(clear),
    .detector(det), .event_flag(flag), .edge_count(cnt), .any_event(any_ev)
  );

  multi_edge_detector #(.CNT_WIDTH(4)) dut4 (
    .clock(clock), .reset_n(reset_n), .data(data), .mode(mode), .clear(clear),
    .detector(det4), .event_flag(flag4), .edge_count(cnt4), .any_event(any_ev4)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("check %-14s observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    reset_n = 1'b0;
    data    = 8'h00;
    mode    = 16'h5555;
    clear   = 8'h00;
    repeat (2) tick();
    chk("rst_det",  {56'b0, det},  64'h0);
    chk("rst_flag", {56'b0, flag}, 64'h0);
    chk("rst_cnt",  cnt,           64'h0);
    chk("rst_any",  {63'b0, any_ev}, 64'h0);

    // Single rising edge on channel 0, six cycles after release.
    reset_n = 1'b1;
    repeat (6) tick();
    data[0] = 1'b1;
    tick(); chk("lat_e0", {56'b0, det}, 64'h0);
    tick(); chk("lat_e1", {56'b0, det}, 64'h0);
    tick(); chk("lat_e2", {56'b0, det}, 64'h01);
    chk("lat_flag", {56'b0, flag}, 64'h01);
    chk("lat_cnt0", {56'b0, cnt[7:0]}, 64'h1);
    chk("lat_any0", {63'b0, any_ev}, 64'h0);
    tick(); chk("lat_e3", {56'b0, det}, 64'h0);
    chk("lat_any1", {63'b0, any_ev}, 64'h1);

    // Inputs held high through reset are not reported as edges.
    reset_n = 1'b0;
    data    = 8'hFF;
    mode    = 16'hFFFF;
    #1;
    chk("async_det",  {56'b0, det},  64'h0);
    chk("async_flag", {56'b0, flag}, 64'h0);
    chk("async_cnt",  cnt,           64'h0);
    chk("async_any",  {63'b0, any_ev}, 64'h0);
    repeat (2) tick();
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick(); chk("prime_det", {56'b0, det}, 64'h0);
    end
    chk("prime_flag", {56'b0, flag}, 64'h0);
    chk("prime_cnt",  cnt,           64'h0);
    data = 8'h00;
    tick(); chk("drop_e0", {56'b0, det}, 64'h0);
    tick(); chk("drop_e1", {56'b0, det}, 64'h0);
    tick(); chk("drop_e2", {56'b0, det}, 64'hFF);
    chk("drop_flag", {56'b0, flag}, 64'hFF);
    chk("drop_cnt",  cnt, 64'h0101010101010101);

    // Channel 2 falling-only then rising-only; all other channels off.
    clear = 8'hFF;
    tick();
    clear = 8'h00;
    chk("clr_flag", {56'b0, flag}, 64'h0);
    chk("clr_cnt",  cnt, 64'h0);
    mode = 16'h0020;
    data[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); chk("fall_norise", {56'b0, det}, 64'h0);
    end
    data[2] = 1'b0;
    tick(); chk("fall_e0", {56'b0, det}, 64'h0);
    tick(); chk("fall_e1", {56'b0, det}, 64'h0);
    tick(); chk("fall_e2", {56'b0, det}, 64'h04);
    tick(); chk("fall_e3", {56'b0, det}, 64'h0);
    mode = 16'h0010;
    data[2] = 1'b1;
    tick(); tick();
    tick(); chk("rise_e2", {56'b0, det}, 64'h04);
    data[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); chk("rise_nofall", {56'b0, det}, 64'h0);
    end
    chk("ch2_cnt",  {56'b0, cnt[23:16]}, 64'h2);
    chk("ch2_flag", {56'b0, flag}, 64'h04);

    // Saturation: 20 back-to-back edges on channel 1 in both-edge mode.
    clear = 8'hFF;
    tick();
    clear = 8'h00;
    mode = 16'h000C;
    for (int i = 0; i < 20; i++) begin
      data[1] = ~data[1];
      tick();
      if (i >= 2) chk("b2b_pulse", {63'b0, det[1]}, 64'h1);
    end
    tick(); chk("b2b_tail0", {63'b0, det[1]}, 64'h1);
    tick(); chk("b2b_tail1", {63'b0, det[1]}, 64'h1);
    tick(); chk("b2b_idle",  {63'b0, det[1]}, 64'h0);
    chk("sat_cnt4", {60'b0, cnt4[7:4]}, 64'hF);
    chk("cnt8_20",  {56'b0, cnt[15:8]}, 64'd20);
    chk("sat_other", {60'b0, cnt4[3:0]}, 64'h0);
    clear = 8'h02;
    tick();
    clear = 8'h00;
    chk("sat_clr_cnt",  {60'b0, cnt4[7:4]}, 64'h0);
    chk("sat_clr_flag", {63'b0, flag4[1]}, 64'h0);

    // Clear coinciding with a qualifying edge on channel 3.
    clear = 8'hFF;
    tick();
    clear = 8'h00;
    tick();
    chk("pre_any", {63'b0, any_ev}, 64'h0);
    mode = 16'h0040;
    data[3] = 1'b1;
    tick(); tick();
    clear = 8'h08;
    tick();
    clear = 8'h00;
    chk("cw_det",  {56'b0, det},  64'h08);
    chk("cw_flag", {56'b0, flag}, 64'h08);
    chk("cw_cnt3", {56'b0, cnt[31:24]}, 64'h1);
    chk("cw_any0", {63'b0, any_ev}, 64'h0);
    tick();
    chk("cw_any1", {63'b0, any_ev}, 64'h1);
    chk("cw_hold", {56'b0, cnt[31:24]}, 64'h1);

    // Reset during a detector pulse, then priming repeats.
    mode = 16'h5555;
    data = 8'h00;
    repeat (3) tick();
    data[0] = 1'b1;
    tick(); tick();
    tick(); chk("mid_det", {56'b0, det}, 64'h01);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_det",  {56'b0, det},  64'h0);
    chk("mid_rst_flag", {56'b0, flag}, 64'h0);
    chk("mid_rst_cnt",  cnt, 64'h0);
    chk("mid_rst_any",  {63'b0, any_ev}, 64'h0);
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick(); chk("reprime_det", {56'b0, det}, 64'h0);
    end
    chk("reprime_flag", {56'b0, flag}, 64'h0);
    data[0] = 1'b0;
    repeat (3) tick();
    data[0] = 1'b1;
    tick(); tick();
    tick(); chk("post_det", {56'b0, det}, 64'h01);
    chk("post_cnt0", {56'b0, cnt[7:0]}, 64'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
